bu2_pair_feeder: RTL

BU2_PAIR_FEEDER -- requirements
Module: bu2_pair_feeder

---
 rtl/bu2_pair_feeder_if.sv | 31 +++
 rtl/bu2_pair_feeder.sv | 134 +++++++++++++
 2 files changed

// File: rtl/bu2_pair_feeder_if.sv
// Handshake bundle between the job controller / loader (master) and the
// butterfly pair feeder (slave).
interface bu2_pair_feeder_if #(
  parameter int BIT_SIZE = 60,
  parameter int LOG_N    = 3
);
  logic                start;
  logic [LOG_N-1:0]    stage;
  logic [BIT_SIZE-1:0] q_in;
  logic                in_valid;
  logic [BIT_SIZE-1:0] in_data;
  logic                in_ready;
  logic [BIT_SIZE-1:0] A0;
  logic [BIT_SIZE-1:0] A1;
  logic [BIT_SIZE-1:0] Y;
  logic [BIT_SIZE-1:0] q;
  logic                out_valid;
  logic                out_ready;
  logic                busy;
  logic                done;

  modport master (
    output start, stage, q_in, in_valid, in_data, out_ready,
    input  in_ready, A0, A1, Y, q, out_valid, busy, done
  );

  modport slave (
    input  start, stage, q_in, in_valid, in_data, out_ready,
    output in_ready, A0, A1, Y, q, out_valid, busy, done
  );
endinterface

// File: rtl/bu2_pair_feeder.sv
// Loads N coefficients and N/2 twiddles, then issues the N/2 radix-2
// butterfly operand pairs of one NTT stage, one pair per accepted transfer.
module bu2_pair_feeder #(
  parameter int BIT_SIZE = 60,
  parameter int LOG_N    = 3
) (
  input logic            clk,
  input logic            rstn,
  bu2_pair_feeder_if.slave bus
);
  localparam int N  = 1 << LOG_N;
  localparam int NH = N / 2;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_ISSUE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [LOG_N:0]   LOAD_LAST = (LOG_N+1)'(N + NH - 1);
  localparam logic [LOG_N-1:0] PAIR_LAST = LOG_N'(NH - 1);

  logic [1:0]          state;
  logic [LOG_N:0]      load_cnt;
  logic [LOG_N-1:0]    pair_cnt;
  logic [LOG_N-1:0]    stage_r;
  logic                vld_p1;
  logic [BIT_SIZE-1:0] a0_p1;
  logic [BIT_SIZE-1:0] a1_p1;
  logic [BIT_SIZE-1:0] y_p1;
  logic [BIT_SIZE-1:0] q_p1;

  logic [BIT_SIZE-1:0] coeff [N];
  logic [BIT_SIZE-1:0] tw    [NH];

  logic                stage_ok;
  logic [LOG_N-1:0]    nxt_k;
  logic [LOG_N-1:0]    sh;
  logic [LOG_N-1:0]    h;
  logic [LOG_N-1:0]    j;
  logic [LOG_N-1:0]    g;
  logic [LOG_N-1:0]    i0;
  logic [LOG_N-1:0]    i1;
  logic [LOG_N-2:0]    ti;

  assign stage_ok = ({1'b0, bus.stage} < (LOG_N+1)'(LOG_N));

  // Index of the pair to present next: 0 when leaving LOAD, k+1 in ISSUE.
  // h = 2^(LOG_N-1-stage), so the divide/modulo by h become shift/mask.
  always_comb begin
    nxt_k = (state == S_ISSUE) ? pair_cnt + LOG_N'(1) : '0;
    sh    = LOG_N'(LOG_N - 1) - stage_r;
    h     = LOG_N'(1) << sh;
    j     = nxt_k & (h - LOG_N'(1));
    g     = nxt_k >> sh;
    i0    = (g << (sh + LOG_N'(1))) | j;
    i1    = i0 | h;
    ti    = (LOG_N-1)'(j << stage_r);
  end

  // Operand storage: never reset, every job rewrites it completely.
  always_ff @(posedge clk) begin
    if (state == S_LOAD && bus.in_valid) begin
      if (!load_cnt[LOG_N])
        coeff[load_cnt[LOG_N-1:0]] <= bus.in_data;
      else
        tw[load_cnt[LOG_N-2:0]] <= bus.in_data;
    end
  end

  // Control FSM and registered output pair (stage p1).
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= S_IDLE;
      load_cnt <= '0;
      pair_cnt <= '0;
      stage_r  <= '0;
      vld_p1   <= 1'b0;
      a0_p1    <= '0;
      a1_p1    <= '0;
      y_p1     <= '0;
      q_p1     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start && stage_ok) begin
            state    <= S_LOAD;
            stage_r  <= bus.stage;
            q_p1     <= bus.q_in;
            load_cnt <= '0;
            pair_cnt <= '0;
          end
        end
        S_LOAD: begin
          if (bus.in_valid) begin
            load_cnt <= load_cnt + (LOG_N+1)'(1);
            if (load_cnt == LOAD_LAST) begin
              state    <= S_ISSUE;
              vld_p1   <= 1'b1;
              pair_cnt <= '0;
              a0_p1    <= coeff[i0];
              a1_p1    <= coeff[i1];
              y_p1     <= tw[ti];
            end
          end
        end
        S_ISSUE: begin
          if (bus.out_ready) begin
            if (pair_cnt == PAIR_LAST) begin
              state  <= S_DONE;
              vld_p1 <= 1'b0;
            end else begin
              pair_cnt <= nxt_k;
              a0_p1    <= coeff[i0];
              a1_p1    <= coeff[i1];
              y_p1     <= tw[ti];
            end
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = (state == S_LOAD);
  assign bus.busy      = (state != S_IDLE);
  assign bus.done      = (state == S_DONE);
  assign bus.out_valid = vld_p1;
  assign bus.A0        = a0_p1;
  assign bus.A1        = a1_p1;
  assign bus.Y         = y_p1;
  assign bus.q         = q_p1;
endmodule
